// File: rtl/fpgaminer_nonce_dispatcher.sv
// Nonce dispatcher: spreads one job's nonce range over NUM_CORES hashing lanes and queues golden nonces.
// Define MINER_STATS_EN to add hash_count, the number of active-lane nonces issued for the current job.
module fpgaminer_nonce_dispatcher #(
  parameter int NUM_CORES    = 4,
  parameter int LOOP_LOG2    = 5,
  parameter int PIPE_ISSUES  = 2,
  parameter int RESULT_DEPTH = 8
) (
  input  logic                     hash_clk,
  input  logic                     reset_n,
  // job_* and result_* are valid/ready pairs: a transfer happens on a rising edge with valid and ready both high.
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [255:0]             job_midstate,
  input  logic [95:0]              job_data,
  input  logic [31:0]              job_nonce_min,
  input  logic [31:0]              job_nonce_max,
  input  logic                     abort,
  output logic [255:0]             core_midstate,
  output logic [95:0]              core_data,
  output logic                     core_load,
  output logic [32*NUM_CORES-1:0]  core_nonce,
  input  logic [NUM_CORES-1:0]     core_hit,
  output logic                     busy,
  output logic                     job_done,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [31:0]              result_nonce,
  output logic [3:0]               result_core,
  output logic [7:0]               drop_count,
  output logic [1:0]               fsm_state
`ifdef MINER_STATS_EN
  ,
  output logic [47:0]              hash_count
`endif
);

  localparam int CW = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;
  localparam int AW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam logic [32:0] STEP = 33'(NUM_CORES);
  localparam logic [31:0] BACK = 32'(PIPE_ISSUES * NUM_CORES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic                   done_nx;
  logic                   accept;
  logic [CW-1:0]          slot_cnt;
  logic [3:0]             drain_cnt;
  logic [31:0]            max_q;
  logic [32:0]            lane_cnt   [NUM_CORES];
  logic [32:0]            next_cnt   [NUM_CORES];
  logic [31:0]            hit_nonce  [NUM_CORES];
  logic [31:0]            pend_nonce [NUM_CORES];
  logic [PIPE_ISSUES-1:0] hist       [NUM_CORES];
  logic [NUM_CORES-1:0]   cur_act, next_act, qual, cand, pending, sel_mask;
  logic                   has_sel;
  logic [3:0]             sel;
  logic [31:0]            sel_nonce;
  logic                   push, pop, full, wr_en;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic [35:0]            mem [RESULT_DEPTH];

  assign busy      = (state != S_IDLE);
  assign job_ready = (state == S_IDLE);
  assign fsm_state = state;
  assign accept    = (state == S_IDLE) && job_valid && !abort;
  assign core_load = busy && (slot_cnt == '0);

  // Lanes keep counting in 33 bits past the range end, so lane_cnt - BACK is always the nonce issued PIPE_ISSUES slots ago.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      next_cnt[i]  = lane_cnt[i] + STEP;
      cur_act[i]   = (lane_cnt[i] <= {1'b0, max_q});
      next_act[i]  = (next_cnt[i] <= {1'b0, max_q});
      qual[i]      = core_load && core_hit[i] && hist[i][PIPE_ISSUES-1];
      hit_nonce[i] = lane_cnt[i][31:0] - BACK;
    end
  end

  // Hits in a slot cycle go out directly; the rest wait in pending, lowest lane first.
  always_comb begin
    cand      = core_load ? qual : pending;
    has_sel   = 1'b0;
    sel       = '0;
    sel_mask  = '0;
    sel_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (cand[i]) begin
        has_sel   = 1'b1;
        sel       = 4'(i);
        sel_mask  = NUM_CORES'(1) << i;
        sel_nonce = core_load ? hit_nonce[i] : pend_nonce[i];
      end
    end
  end

  assign pop   = result_valid && result_ready;
  assign full  = (count == (AW+1)'(RESULT_DEPTH));
  assign push  = has_sel && !abort;
  assign wr_en = push && (!full || pop);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN: begin
        if (abort) state_nx = S_IDLE;
        else if (core_load && (next_act == '0)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort) state_nx = S_IDLE;
        else if (core_load && (drain_cnt == 4'(PIPE_ISSUES - 1))) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      job_done      <= 1'b0;
      core_midstate <= '0;
      core_data     <= '0;
      core_nonce    <= '0;
      max_q         <= '0;
      slot_cnt      <= '0;
      drain_cnt     <= '0;
      pending       <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        lane_cnt[i]   <= '0;
        hist[i]       <= '0;
        pend_nonce[i] <= '0;
      end
    end else begin
      job_done <= done_nx;
      if (accept) begin
        core_midstate <= job_midstate;
        core_data     <= job_data;
        max_q         <= job_nonce_max;
        slot_cnt      <= '0;
        drain_cnt     <= '0;
        for (int i = 0; i < NUM_CORES; i++) begin
          lane_cnt[i]            <= {1'b0, job_nonce_min} + 33'(i);
          core_nonce[32*i +: 32] <= job_nonce_min + 32'(i);
          hist[i]                <= '0;
        end
      end else if (busy) begin
        if (LOOP_LOG2 > 0) slot_cnt <= slot_cnt + 1'b1;
        if (core_load) begin
          if (state == S_DRAIN) drain_cnt <= drain_cnt + 4'd1;
          for (int i = 0; i < NUM_CORES; i++) begin
            lane_cnt[i] <= next_cnt[i];
            if (next_act[i]) core_nonce[32*i +: 32] <= next_cnt[i][31:0];
            hist[i] <= (hist[i] << 1) | PIPE_ISSUES'((state == S_RUN) && cur_act[i]);
          end
        end
      end
      if (core_load) begin
        for (int i = 0; i < NUM_CORES; i++) pend_nonce[i] <= hit_nonce[i];
      end
      if (abort) begin
        pending <= '0;
        for (int i = 0; i < NUM_CORES; i++) hist[i] <= '0;
      end else begin
        pending <= cand & ~sel_mask;
      end
    end
  end

  // Result FIFO; a pop in the same cycle frees the slot for a push even when full.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (wr_en) mem[wr_ptr] <= {sel, sel_nonce};
  end

  assign result_valid = (count != '0);
  assign result_nonce = result_valid ? mem[rd_ptr][31:0]  : '0;
  assign result_core  = result_valid ? mem[rd_ptr][35:32] : '0;

`ifdef MINER_STATS_EN
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) hash_count <= '0;
    else if (accept) hash_count <= '0;
    else if (core_load && (state == S_RUN)) hash_count <= hash_count + 48'($countones(cur_act));
  end
`endif

endmodule
